// File: rtl/calendar_date_counter.sv
// Calendar register for the MSF clock: day/month/year/day-of-week with midnight
// tick advance, leap-year aware month lengths and range-checked date loads.
module calendar_date_counter #(
  parameter int YEAR_W    = 7,
  parameter int YEAR_BASE = 2000,
  parameter int LEAP_MODE = 2,
  parameter int RESET_DOW = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [4:0]        load_day_i,
  input  logic [3:0]        load_month_i,
  input  logic [YEAR_W-1:0] load_year_i,
  input  logic [2:0]        load_dow_i,
  output logic [4:0]        day_o,
  output logic [3:0]        month_o,
  output logic [YEAR_W-1:0] year_o,
  output logic [2:0]        dow_o,
  output logic [4:0]        dim_o,
  output logic              leap_o,
  output logic              valid_o,
  output logic              load_err_o,
  output logic              year_wrap_o
);

  // Leap test works on the full calendar year so century rules see the real value.
  function automatic logic f_is_leap(input logic [YEAR_W-1:0] year);
    logic [31:0] y;
    logic        leap;
    y    = 32'(YEAR_BASE) + 32'(year);
    leap = 1'b0;
    case (LEAP_MODE)
      1:       leap = (y % 32'd4 == 32'd0);
      2:       leap = ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) ||
                      (y % 32'd400 == 32'd0);
      default: leap = 1'b0;
    endcase
    return leap;
  endfunction

  function automatic logic [4:0] f_dim(input logic [3:0] month, input logic leap);
    logic [4:0] dim;
    case (month)
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  logic [4:0]        r_day;
  logic [3:0]        r_month;
  logic [YEAR_W-1:0] r_year;
  logic [2:0]        r_dow;
  logic              r_valid;
  logic              r_load_err;
  logic              r_year_wrap;

  logic              w_leap;
  logic [4:0]        w_dim;
  logic              w_load_leap;
  logic [4:0]        w_load_dim;
  logic              w_load_ok;

  assign w_leap      = f_is_leap(r_year);
  assign w_dim       = f_dim(r_month, w_leap);
  assign w_load_leap = f_is_leap(load_year_i);
  assign w_load_dim  = f_dim(load_month_i, w_load_leap);
  assign w_load_ok   = (load_month_i >= 4'd1) && (load_month_i <= 4'd12) &&
                       (load_day_i >= 5'd1) && (load_day_i <= w_load_dim) &&
                       (load_dow_i <= 3'd6);

  // An accepted load wins over a same-cycle tick; a rejected load lets the tick through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_day       <= 5'd1;
      r_month     <= 4'd1;
      r_year      <= '0;
      r_dow       <= 3'(RESET_DOW);
      r_valid     <= 1'b0;
      r_load_err  <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_load_err  <= load_i && !w_load_ok;
      r_year_wrap <= 1'b0;
      if (load_i && w_load_ok) begin
        r_day   <= load_day_i;
        r_month <= load_month_i;
        r_year  <= load_year_i;
        r_dow   <= load_dow_i;
        r_valid <= 1'b1;
      end else if (tick_i) begin
        r_dow <= (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
        if (r_day < w_dim) begin
          r_day <= r_day + 5'd1;
        end else begin
          r_day <= 5'd1;
          if (r_month < 4'd12) begin
            r_month <= r_month + 4'd1;
          end else begin
            r_month     <= 4'd1;
            r_year      <= r_year + 1'b1;
            r_year_wrap <= (r_year == '1);
          end
        end
      end
    end
  end

  assign day_o       = r_day;
  assign month_o     = r_month;
  assign year_o      = r_year;
  assign dow_o       = r_dow;
  assign dim_o       = w_dim;
  assign leap_o      = w_leap;
  assign valid_o     = r_valid;
  assign load_err_o  = r_load_err;
  assign year_wrap_o = r_year_wrap;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: leap/century rules, rollovers,
// load validation, load/tick priority and asynchronous reset.
module tb_calendar_date_counter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       load_i = 1'b0;
  logic [4:0] load_day_i = 5'd0;
  logic [3:0] load_month_i = 4'd0;
  logic [6:0] load_year_i = 7'd0;
  logic [2:0] load_dow_i = 3'd0;
  logic [4:0] day_o;
  logic [3:0] month_o;
  logic [6:0] year_o;
  logic [2:0] dow_o;
  logic [4:0] dim_o;
  logic       leap_o;
  logic       valid_o;
  logic       load_err_o;
  logic       year_wrap_o;

  int testsRun = 0;
  int testsFailed = 0;

  calendar_date_counter #(
    .YEAR_W(7), .YEAR_BASE(2000), .LEAP_MODE(2), .RESET_DOW(6)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i), .load_i(load_i),
    .load_day_i(load_day_i), .load_month_i(load_month_i),
    .load_year_i(load_year_i), .load_dow_i(load_dow_i),
    .day_o(day_o), .month_o(month_o), .year_o(year_o), .dow_o(dow_o),
    .dim_o(dim_o), .leap_o(leap_o), .valid_o(valid_o),
    .load_err_o(load_err_o), .year_wrap_o(year_wrap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [18:0] state();
    return {day_o, month_o, year_o, dow_o};
  endfunction

  // One clock of stimulus; returns #1 after the sampling edge with pulses cleared.
  task automatic applyStimulus(input logic ld, input logic tk, input logic [4:0] d,
                               input logic [3:0] m, input logic [6:0] y,
                               input logic [2:0] w);
    @(negedge clk_i);
    load_i = ld; tick_i = tk;
    load_day_i = d; load_month_i = m; load_year_i = y; load_dow_i = w;
    @(posedge clk_i);
    #1;
    load_i = 1'b0; tick_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    testsRun++;
    if (state() !== {5'd1, 4'd1, 7'd0, 3'd6}) begin
      testsFailed++; $display("[TB] FAIL reset_state got %h want %h", state(), {5'd1, 4'd1, 7'd0, 3'd6});
    end
    testsRun++;
    if ({valid_o, load_err_o, year_wrap_o, leap_o, dim_o} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd31}) begin
      testsFailed++; $display("[TB] FAIL reset_flags got %b want %b",
        {valid_o, load_err_o, year_wrap_o, leap_o, dim_o}, {1'b0, 1'b0, 1'b0, 1'b1, 5'd31});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_invalid_loads();
    logic [18:0] bad [6];
    bad[0] = {5'd30, 4'd2, 7'd24, 3'd3};
    bad[1] = {5'd31, 4'd4, 7'd24, 3'd3};
    bad[2] = {5'd5, 4'd0, 7'd24, 3'd3};
    bad[3] = {5'd5, 4'd13, 7'd24, 3'd3};
    bad[4] = {5'd0, 4'd5, 7'd24, 3'd3};
    bad[5] = {5'd5, 4'd5, 7'd24, 3'd7};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, bad[i][18:14], bad[i][13:10], bad[i][9:3], bad[i][2:0]);
      testsRun++;
      if ({load_err_o, valid_o, state()} !== {1'b1, 1'b0, 5'd1, 4'd1, 7'd0, 3'd6}) begin
        testsFailed++; $display("[TB] FAIL invalid_load_%0d got %h want %h", i,
          {load_err_o, valid_o, state()}, {1'b1, 1'b0, 5'd1, 4'd1, 7'd0, 3'd6});
      end
      @(posedge clk_i);
      #1;
      testsRun++;
      if (load_err_o !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL invalid_err_clear_%0d got %b want 0", i, load_err_o);
      end
    end
  endtask

  task automatic test_leap_feb();
    applyStimulus(1'b1, 1'b0, 5'd28, 4'd2, 7'd24, 3'd3);
    testsRun++;
    if ({valid_o, load_err_o, leap_o, dim_o, state()} !== {1'b1, 1'b0, 1'b1, 5'd29, 5'd28, 4'd2, 7'd24, 3'd3}) begin
      testsFailed++; $display("[TB] FAIL leap_load got %h want %h", {valid_o, load_err_o, leap_o, dim_o, state()},
        {1'b1, 1'b0, 1'b1, 5'd29, 5'd28, 4'd2, 7'd24, 3'd3});
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 7'd0, 3'd0);
    testsRun++;
    if (state() !== {5'd29, 4'd2, 7'd24, 3'd4}) begin
      testsFailed++; $display("[TB] FAIL leap_29feb got %h want %h", state(), {5'd29, 4'd2, 7'd24, 3'd4});
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 7'd0, 3'd0);
    testsRun++;
    if ({dim_o, state()} !== {5'd31, 5'd1, 4'd3, 7'd24, 3'd5}) begin
      testsFailed++; $display("[TB] FAIL leap_1mar got %h want %h", {dim_o, state()}, {5'd31, 5'd1, 4'd3, 7'd24, 3'd5});
    end
  endtask

  task automatic test_century();
    logic [6:0] yrs [3];
    logic       lp [3];
    yrs[0] = 7'd23;  lp[0] = 1'b0;
    yrs[1] = 7'd100; lp[1] = 1'b0;
    yrs[2] = 7'd0;   lp[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd28, 4'd2, yrs[i], 3'd0);
      testsRun++;
      if ({leap_o, dim_o} !== {lp[i], lp[i] ? 5'd29 : 5'd28}) begin
        testsFailed++; $display("[TB] FAIL century_dim_%0d got %h want %h", i, {leap_o, dim_o}, {lp[i], lp[i] ? 5'd29 : 5'd28});
      end
      applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 7'd0, 3'd0);
      testsRun++;
      if (state() !== (lp[i] ? {5'd29, 4'd2, yrs[i], 3'd1} : {5'd1, 4'd3, yrs[i], 3'd1})) begin
        testsFailed++; $display("[TB] FAIL century_tick_%0d got %h want %h", i, state(),
          lp[i] ? {5'd29, 4'd2, yrs[i], 3'd1} : {5'd1, 4'd3, yrs[i], 3'd1});
      end
    end
  endtask

  task automatic test_year_wrap();
    applyStimulus(1'b1, 1'b0, 5'd31, 4'd12, 7'd5, 3'd6);
    applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 7'd0, 3'd0);
    testsRun++;
    if ({year_wrap_o, state()} !== {1'b0, 5'd1, 4'd1, 7'd6, 3'd0}) begin
      testsFailed++; $display("[TB] FAIL new_year got %h want %h", {year_wrap_o, state()}, {1'b0, 5'd1, 4'd1, 7'd6, 3'd0});
    end
    applyStimulus(1'b1, 1'b0, 5'd31, 4'd12, 7'd127, 3'd2);
    applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 7'd0, 3'd0);
    testsRun++;
    if ({year_wrap_o, state()} !== {1'b1, 5'd1, 4'd1, 7'd0, 3'd3}) begin
      testsFailed++; $display("[TB] FAIL year_wrap got %h want %h", {year_wrap_o, state()}, {1'b1, 5'd1, 4'd1, 7'd0, 3'd3});
    end
    @(posedge clk_i);
    #1;
    testsRun++;
    if (year_wrap_o !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL year_wrap_clear got %b want 0", year_wrap_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp [3];
    exp[0] = {5'd1, 4'd5, 7'd10, 3'd1};
    exp[1] = {5'd2, 4'd5, 7'd10, 3'd2};
    exp[2] = {5'd3, 4'd5, 7'd10, 3'd3};
    applyStimulus(1'b1, 1'b0, 5'd30, 4'd4, 7'd10, 3'd0);
    @(negedge clk_i);
    tick_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      testsRun++;
      if (state() !== exp[i]) begin
        testsFailed++; $display("[TB] FAIL back_to_back_%0d got %h want %h", i, state(), exp[i]);
      end
    end
    tick_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b1, 1'b0, 5'd10, 4'd10, 7'd10, 3'd4);
    applyStimulus(1'b1, 1'b1, 5'd15, 4'd6, 7'd30, 3'd2);
    testsRun++;
    if ({load_err_o, state()} !== {1'b0, 5'd15, 4'd6, 7'd30, 3'd2}) begin
      testsFailed++; $display("[TB] FAIL load_beats_tick got %h want %h", {load_err_o, state()}, {1'b0, 5'd15, 4'd6, 7'd30, 3'd2});
    end
    applyStimulus(1'b1, 1'b0, 5'd10, 4'd10, 7'd10, 3'd4);
    applyStimulus(1'b1, 1'b1, 5'd31, 4'd2, 7'd10, 3'd0);
    testsRun++;
    if ({load_err_o, state()} !== {1'b1, 5'd11, 4'd10, 7'd10, 3'd5}) begin
      testsFailed++; $display("[TB] FAIL bad_load_tick got %h want %h", {load_err_o, state()}, {1'b1, 5'd11, 4'd10, 7'd10, 3'd5});
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 5'd15, 4'd8, 7'd42, 3'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    testsRun++;
    if ({valid_o, state()} !== {1'b0, 5'd1, 4'd1, 7'd0, 3'd6}) begin
      testsFailed++; $display("[TB] FAIL async_reset got %h want %h", {valid_o, state()}, {1'b0, 5'd1, 4'd1, 7'd0, 3'd6});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_invalid_loads();
    test_leap_feb();
    test_century();
    test_year_wrap();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
